// File: rtl/button_event_master.sv
// rtl/button_event_master.sv - Avalon-MM initiator servicing a button PIO edge-capture slave.
// Optional BUTTON_EVENT_TIMESTAMP_EN adds a per-event 32-bit cycle timestamp (evt_time).
module button_event_master #(
  parameter int unsigned      WIDTH         = 4,
  parameter int unsigned      FIFO_DEPTH    = 8,
  parameter logic [WIDTH-1:0] IRQ_MASK_INIT = 4'hF,
  parameter int unsigned      READ_LATENCY  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             irq,
  output logic [1:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [31:0]      avm_writedata,
  input  logic [31:0]      avm_readdata,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_edges,
  output logic [WIDTH-1:0] evt_levels,
`ifdef BUTTON_EVENT_TIMESTAMP_EN
  output logic [31:0]      evt_time,
`endif
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
`ifdef BUTTON_EVENT_TIMESTAMP_EN
  localparam int unsigned EW = 2 * WIDTH + 32;
`else
  localparam int unsigned EW = 2 * WIDTH;
`endif
  localparam logic [1:0] WAIT_LAST = 2'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_RD_EDGE, S_WAIT_E, S_CLR, S_RD_LVL, S_WAIT_L, S_PUSH
  } state_t;

  state_t           state_q, state_d;
  logic             start_q, start_d;
  logic [1:0]       wcnt_q, wcnt_d;
  logic [WIDTH-1:0] edges_q, edges_d;
  logic [WIDTH-1:0] levels_q, levels_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;
  logic [EW-1:0]    mem_q [FIFO_DEPTH];
  logic [EW-1:0]    entry_w, head_w;
  logic             push, pop, push_ok, fifo_empty, fifo_full;
  logic             unused_readdata;

  assign unused_readdata = ^avm_readdata[31:WIDTH];

  // start_q keeps the bus idle for the first cycle out of reset so the reset values are visible.
  always_comb begin
    state_d        = state_q;
    start_d        = 1'b1;
    wcnt_d         = wcnt_q;
    edges_d        = edges_q;
    levels_d       = levels_q;
    push           = 1'b0;
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_address    = 2'd0;
    avm_writedata  = 32'd0;
    case (state_q)
      S_INIT: begin
        if (start_q) begin
          avm_chipselect = 1'b1;
          avm_write_n    = 1'b0;
          avm_address    = 2'd2;
          avm_writedata  = 32'(IRQ_MASK_INIT);
          state_d        = S_IDLE;
        end
      end
      S_IDLE: if (irq) state_d = S_RD_EDGE;
      S_RD_EDGE: begin
        avm_chipselect = 1'b1;
        avm_address    = 2'd3;
        wcnt_d         = 2'd0;
        state_d        = S_WAIT_E;
      end
      S_WAIT_E: begin
        if (wcnt_q == WAIT_LAST) begin
          edges_d = avm_readdata[WIDTH-1:0];
          state_d = (avm_readdata[WIDTH-1:0] == '0) ? S_IDLE : S_CLR;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      S_CLR: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = 2'd3;
        avm_writedata  = 32'(edges_q);
        state_d        = S_RD_LVL;
      end
      S_RD_LVL: begin
        avm_chipselect = 1'b1;
        avm_address    = 2'd0;
        wcnt_d         = 2'd0;
        state_d        = S_WAIT_L;
      end
      S_WAIT_L: begin
        if (wcnt_q == WAIT_LAST) begin
          levels_d = avm_readdata[WIDTH-1:0];
          state_d  = S_PUSH;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      S_PUSH: begin
        push    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = !fifo_empty && evt_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok    = push && (!fifo_full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !push_ok) overflow_d = 1'b1;
  end

`ifdef BUTTON_EVENT_TIMESTAMP_EN
  logic [31:0] cyc_q, cyc_d, ts_q, ts_d;

  always_comb begin
    cyc_d = cyc_q + 32'd1;
    ts_d  = ts_q;
    if (state_q == S_IDLE && irq) ts_d = cyc_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q <= 32'd0;
      ts_q  <= 32'd0;
    end else begin
      cyc_q <= cyc_d;
      ts_q  <= ts_d;
    end
  end

  assign entry_w  = {ts_q, edges_q, levels_q};
  assign evt_time = head_w[EW-1:2*WIDTH];
`else
  assign entry_w = {edges_q, levels_q};
`endif

  assign head_w     = mem_q[rd_ptr_q[AW-1:0]];
  assign evt_valid  = !fifo_empty;
  assign evt_edges  = head_w[2*WIDTH-1:WIDTH];
  assign evt_levels = head_w[WIDTH-1:0];
  assign overflow   = overflow_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_INIT;
      start_q    <= 1'b0;
      wcnt_q     <= 2'd0;
      edges_q    <= '0;
      levels_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      wcnt_q     <= wcnt_d;
      edges_q    <= edges_d;
      levels_q   <= levels_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= entry_w;
  end

endmodule

// File: doc/button_event_master.md
Name: button_event_master

Overview:
- Avalon-MM initiator that services the 4-bit button PIO's edge-capture slave in hardware, replacing NIOS II polling.
- Programs the PIO interrupt mask, then waits for the PIO irq.
- On each irq it reads the edge-capture register, clears it, and reads the live levels.
- Pushes one {edges, levels} event per interrupt into a small FIFO for the game FSM.

Parameters:
- WIDTH, 4, button count; must match the PIO data width.
- FIFO_DEPTH, 8, event FIFO entries; power of two, minimum 2.
- IRQ_MASK_INIT, 4'hF, value written to PIO address 2 after reset.
- READ_LATENCY, 1, cycles from address/chipselect to valid avm_readdata; range 1 to 3.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- irq  in  1  PIO interrupt; level-sensitive.
- avm_address  out  2  PIO register select: 0 = data, 2 = irq_mask, 3 = edge_capture.
- avm_chipselect  out  1  bus cycle active.
- avm_write_n  out  1  0 = write, 1 = read.
- avm_writedata  out  32  write data; upper bits are zero.
- avm_readdata  in  32  slave read data; only [WIDTH-1:0] is used.
- evt_valid  out  1  FIFO not empty.
- evt_ready  in  1  consumer accepts the head entry.
- evt_edges  out  WIDTH  captured rising edges at the FIFO head.
- evt_levels  out  WIDTH  button levels at the FIFO head.
- overflow  out  1  sticky; an event was dropped because the FIFO was full.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset values:
  - FSM = INIT.
  - avm_chipselect = 0, avm_write_n = 1, avm_address = 0, avm_writedata = 0.
  - FIFO empty, evt_valid = 0, overflow = 0, busy = 1.
  - Reset mid-transaction aborts the transaction, empties the FIFO and restarts at INIT.
- Bus cycles:
  - Writes take 1 cycle: chipselect = 1, write_n = 0, address and writedata valid for exactly one clk.
  - Reads: chipselect = 1, write_n = 1, address held for 1 cycle. avm_readdata is sampled READ_LATENCY cycles after the address cycle. Bus is idle (chipselect = 0) while waiting.
  - Never more than one outstanding transaction.
- FSM:
  - INIT: write IRQ_MASK_INIT to address 2 -> IDLE.
  - IDLE: busy = 0. If irq = 1 -> RD_EDGE.
  - RD_EDGE: read address 3 -> WAIT_E, which counts READ_LATENCY cycles. Latch edges = readdata[WIDTH-1:0].
    - If edges == 0 (spurious irq): -> IDLE, no event.
    - Otherwise -> CLR.
  - CLR: write the latched edges to address 3. The slave clears all capture bits on any write to address 3. -> RD_LVL.
  - RD_LVL: read address 0 -> WAIT_L. Latch levels -> PUSH.
  - PUSH: one cycle.
    - If the FIFO is not full, enqueue {edges, levels}.
    - If full, drop the event and set overflow.
    - -> IDLE.
- Edge race: an edge captured between RD_EDGE and CLR is lost. This is accepted and documented.
- Minimum service latency with READ_LATENCY = 1, counted from irq sampled high in IDLE to the PUSH cycle: 7 cycles. evt_valid rises the cycle after PUSH.
- irq still high on return to IDLE (new edge after CLR): a new service cycle starts immediately.
- FIFO:
  - Show-ahead; evt_edges and evt_levels are the head entry whenever evt_valid = 1.
  - Dequeue when evt_valid && evt_ready.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
  - Simultaneous push and pop when full: the pop frees the slot, the push succeeds, no overflow.
  - Pop when empty is ignored.
- overflow clears only on reset.

Optional Feature:
- Macro BUTTON_EVENT_TIMESTAMP_EN.
- Defined:
  - Adds a 32-bit free-running cycle counter: reset to 0, increments every clk, wraps.
  - Adds output port evt_time (32 bits), stored per FIFO entry.
  - The stored value is the counter as sampled in the cycle irq was first seen high in IDLE.
- Undefined: no counter, no evt_time port; FIFO width is 2*WIDTH.

Test Plan:
- Reset release -> first bus cycle is a write: address 2, writedata 0x0000000F. Then idle with chipselect = 0 and busy = 0.
- irq = 1, readdata at address 3 returns 0x2, at address 0 returns 0x3 (READ_LATENCY = 1) -> write of 0x2 to address 3. evt_valid = 1 with edges 0x2 and levels 0x3, 8 cycles after irq seen.
- irq pulse with address-3 readdata 0x0 -> no write to address 3, no address-0 read, evt_valid stays 0.
- 9 interrupts, evt_ready = 0, FIFO_DEPTH = 8 -> 8 entries held, overflow = 1 after the 9th PUSH. Then evt_ready = 1 drains entries 1 to 8 in order.
- FIFO full with evt_ready = 1 in the PUSH cycle -> no overflow, count stays 8.
- Reset asserted during WAIT_L -> next cycle chipselect = 0 and FIFO empty. Restart begins with the address-2 mask write.
